// File: rtl/uart_tx_queue.sv
// uart_tx_queue: host-side byte FIFO plus launch sequencer for the UART
// transmitter. Words are accepted on wr_valid/wr_ready, buffered, and handed
// to the transmitter one at a time on TxData/transmit, paced by busy.
// Optional macro UART_TXQ_LEVEL_EN adds a registered 'level' output (fill count).
module uart_tx_queue #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   TxData,
  output logic                    transmit,
  input  logic                    busy,
`ifdef UART_TXQ_LEVEL_EN
  output logic [$clog2(DEPTH):0]  level,
`endif
  output logic                    full,
  output logic                    empty
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, LAUNCH, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]       wptr_q, rptr_q;
  logic [ADDR_W:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0]   txdata_q, txdata_d;
  logic                    transmit_q, transmit_d;
  logic                    push, pop;

  // Status flags come straight from the registered count; no write bypass.
  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign TxData   = txdata_q;
  assign transmit = transmit_q;
`ifdef UART_TXQ_LEVEL_EN
  assign level    = count_q;
`endif

  // Launch sequencer: pop the head only when idle and the line is free,
  // hold transmit until the transmitter acknowledges with busy, then wait
  // for the frame to finish before considering the next word.
  always_comb begin
    state_d    = state_q;
    txdata_d   = txdata_q;
    transmit_d = transmit_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !busy) begin
          txdata_d   = mem_q[rptr_q];
          pop        = 1'b1;
          transmit_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        if (busy) begin
          transmit_d = 1'b0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (!busy) state_d = IDLE;
      end
      default: begin
        transmit_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control state, pointers and launch registers; reset discards the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      txdata_q   <= '0;
      transmit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      txdata_q   <= txdata_d;
      transmit_q <= transmit_d;
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a scoreboard queue of accepted words is compared
// against each launch; a simple transmitter model drives busy.
module tb_uart_tx_queue;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] TxData;
  logic          transmit;
  logic          busy = 1'b0;
  logic          full, empty;
`ifdef UART_TXQ_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  uart_tx_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .TxData(TxData), .transmit(transmit), .busy(busy),
`ifdef UART_TXQ_LEVEL_EN
    .level(level),
`endif
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transmitter model ----------------
  logic force_busy = 1'b0;
  int   frame_len  = 4;
  logic tx_seen = 1'b0, rst_seen = 1'b1;
  int   bcnt = 0;

  always @(negedge clk) begin
    tx_seen  = transmit;
    rst_seen = reset;
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rst_seen) begin busy = 1'b0; bcnt = 0; end
      else if (force_busy) begin busy = 1'b1; bcnt = 0; end
      else if (bcnt > 1) bcnt--;
      else if (bcnt == 1 || busy) begin busy = 1'b0; bcnt = 0; end
      else if (tx_seen) begin busy = 1'b1; bcnt = frame_len; end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] expq[$];
  int            mcnt = 0;
  logic          prev_reset = 1'b1, prev_valid = 1'b0, prev_tx = 1'b0, busy_prev = 1'b0;
  logic [DW-1:0] prev_data = '0, launched_word = '0;
  logic          after_launch = 1'b0, gap_armed = 1'b0;
  int            ncyc = 0, fall_cyc = 0, launches = 0;

  always @(negedge clk) begin
    ncyc++;
    if (prev_reset) begin
      expq.delete();
      mcnt = 0; after_launch = 1'b0; gap_armed = 1'b0;
      chk("rst_transmit", transmit, 0);
      chk("rst_txdata", TxData, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_wr_ready", wr_ready, 1);
    end else begin
      if (prev_valid && mcnt < DEPTH) begin
        expq.push_back(prev_data);
        mcnt++;
      end
      if (busy_prev && !busy && after_launch) begin
        fall_cyc = ncyc; gap_armed = 1'b1; after_launch = 1'b0;
      end
      if (transmit && !prev_tx) begin
        launches++;
        chk("launch_while_busy", busy_prev, 0);
        if (gap_armed) chk("launch_gap_ok", (ncyc - fall_cyc >= 2), 1);
        gap_armed = 1'b0; after_launch = 1'b1;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL launch_order: got launch of %0h expected no launch at %0t", TxData, $time);
        end else begin
          chk("launch_data", TxData, expq.pop_front());
          mcnt--;
        end
        launched_word = TxData;
      end else if (transmit) begin
        chk("txdata_stable", TxData, launched_word);
      end
      chk("empty", empty, mcnt == 0);
      chk("full", full, mcnt == DEPTH);
      chk("wr_ready", wr_ready, mcnt != DEPTH);
    end
`ifdef UART_TXQ_LEVEL_EN
    if (!prev_reset) chk("level", level, mcnt);
`endif
    prev_reset = reset;
    prev_valid = wr_valid;
    prev_data  = wr_data;
    prev_tx    = transmit;
    busy_prev  = busy;
  end

  // ---------------- stimulus helpers (called at posedge+#1) ----------------
  task automatic idle(input int n);
    wr_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a word and return right after the edge that accepts it.
  task automatic drive_push(input logic [DW-1:0] b);
    wr_valid = 1'b1; wr_data = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        @(posedge clk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL push_timeout: got no wr_ready expected accept of %0h", b);
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    logic done;
    done = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < n && !done; i++) begin
      @(negedge clk);
      if (mcnt == 0 && !transmit && !busy) done = 1'b1;
    end
    chk("drain_done", done, 1);
    chk("drain_empty", empty, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  initial begin
    // Reset for two cycles, then idle: no spurious launch allowed.
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(10);
    chk("idle_transmit", transmit, 0);

    // Single word latency: accepted at edge E, transmit visible after E+1.
    frame_len = 5;
    wr_valid = 1'b1; wr_data = 8'hA5;
    @(posedge clk); #1 wr_valid = 1'b0;
    @(negedge clk); chk("lat_not_yet", transmit, 0);
    @(negedge clk); chk("lat_transmit", transmit, 1); chk("lat_data", TxData, 8'hA5);
    @(posedge clk); #1;
    wait_drain(200);

    // Burst of three with 10-cycle frames.
    frame_len = 10;
    drive_push(8'h01); drive_push(8'h02); drive_push(8'h03);
    wait_drain(500);

    // Fill to DEPTH while the line is held busy; 17th word must wait.
    force_busy = 1'b1;
    idle(2);
    for (int i = 0; i < DEPTH; i++) drive_push(8'h10 + 8'(i));
    wr_valid = 1'b1; wr_data = 8'h20;
    @(negedge clk); chk("fill_full", full, 1); chk("fill_wr_ready", wr_ready, 0);
    repeat (3) @(posedge clk);
    #1 force_busy = 1'b0;
    frame_len = 3;
    drive_push(8'h20);
    wait_drain(2000);

    // Reset while a launch is pending; remaining words must never launch.
    frame_len = 8;
    force_busy = 1'b1;
    idle(2);
    for (int i = 0; i < 5; i++) drive_push(8'h40 + 8'(i));
    wr_valid = 1'b0;
    force_busy = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (transmit) seen = 1'b1;
      end
      chk("mid_launch_seen", seen, 1);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(40);
    chk("post_reset_empty", empty, 1);

    // Randomized traffic with varying frame lengths.
    for (int i = 0; i < 600; i++) begin
      frame_len = $urandom_range(1, 12);
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_data   = 8'($urandom);
      @(posedge clk); #1;
    end
    wait_drain(4000);
    chk("launches_seen", launches > 20, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
